// File: rtl/scene_ctrl.sv
// scene_ctrl -- game-screen sequencer.
//   Steps TITLE -> SELECT -> PLAY -> RESULT -> SELECT. Every scene switch
//   passes through a timed BLANK scene (BLANK_CYC cycles) during which all
//   inputs are ignored. All outputs are registered.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   change       1-cycle pulse (synchronised button press)
//   next_song    1-cycle pulse, advance song selection while in SELECT
//   song_end     1-cycle pulse from sound block, song finished (PLAY only)
//   scene        0 TITLE, 1 SELECT, 2 PLAY, 3 RESULT, 4 BLANK
//   song_idx     selected song, 0..NUM_SONGS-1
//   play_en      high only while scene==PLAY
//   scene_start  1-cycle pulse on the first cycle of a new non-BLANK scene
//   busy         high while scene==BLANK
module scene_ctrl #(
  parameter int NUM_SONGS = 4,
  parameter int IDX_W     = 2,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             change,
  input  logic             next_song,
  input  logic             song_end,
  output logic [2:0]       scene,
  output logic [IDX_W-1:0] song_idx,
  output logic             play_en,
  output logic             scene_start,
  output logic             busy
);

  localparam int CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SONGS - 1);

  typedef enum logic [2:0] {
    TITLE  = 3'd0,
    SELECT = 3'd1,
    PLAY   = 3'd2,
    RESULT = 3'd3,
    BLANK  = 3'd4
  } scene_t;

  scene_t           scene_q, scene_n;
  scene_t           target_q, target_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             play_en_q, play_en_n;
  logic             start_q, start_n;
  logic             busy_q, busy_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scene_q   <= TITLE;
      target_q  <= TITLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      play_en_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      scene_q   <= scene_n;
      target_q  <= target_n;
      cnt_q     <= cnt_n;
      idx_q     <= idx_n;
      play_en_q <= play_en_n;
      start_q   <= start_n;
      busy_q    <= busy_n;
    end
  end

  always_comb begin
    scene_n  = scene_q;
    target_n = target_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    start_n  = 1'b0;

    case (scene_q)
      TITLE: begin
        if (change) begin
          scene_n  = BLANK;
          target_n = SELECT;
          cnt_n    = CNT_LOAD;
        end
      end
      SELECT: begin
        // change has priority: a simultaneous next_song is dropped
        if (change) begin
          scene_n  = BLANK;
          target_n = PLAY;
          cnt_n    = CNT_LOAD;
        end else if (next_song) begin
          idx_n = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      PLAY: begin
        if (change || song_end) begin
          scene_n  = BLANK;
          target_n = RESULT;
          cnt_n    = CNT_LOAD;
        end
      end
      RESULT: begin
        if (change) begin
          scene_n  = BLANK;
          target_n = SELECT;
          cnt_n    = CNT_LOAD;
        end
      end
      BLANK: begin
        // counter runs BLANK_CYC-1 .. 0, so BLANK lasts BLANK_CYC cycles
        if (cnt_q == '0) begin
          scene_n = target_q;
          start_n = 1'b1;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: scene_n = TITLE;
    endcase

    // flags follow the next scene so they are registered alongside it
    play_en_n = (scene_n == PLAY);
    busy_n    = (scene_n == BLANK);
  end

  assign scene       = scene_q;
  assign song_idx    = idx_q;
  assign play_en     = play_en_q;
  assign scene_start = start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_scene_ctrl.sv
module tb_scene_ctrl;

  localparam int NUM_SONGS = 3;
  localparam int IDX_W     = 2;
  localparam int BLANK_CYC = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             change;
  logic             next_song;
  logic             song_end;
  logic [2:0]       scene;
  logic [IDX_W-1:0] song_idx;
  logic             play_en;
  logic             scene_start;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int starts;

  scene_ctrl #(
    .NUM_SONGS(NUM_SONGS),
    .IDX_W    (IDX_W),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .change     (change),
    .next_song  (next_song),
    .song_end   (song_end),
    .scene      (scene),
    .song_idx   (song_idx),
    .play_en    (play_en),
    .scene_start(scene_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] sc, input logic [1:0] idx,
                           input logic pe, input logic ss, input logic bz);
    chk({tag, ".scene"}, 32'(scene), 32'(sc));
    chk({tag, ".song_idx"}, 32'(song_idx), 32'(idx));
    chk({tag, ".play_en"}, 32'(play_en), 32'(pe));
    chk({tag, ".scene_start"}, 32'(scene_start), 32'(ss));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    rst_n = 1'b0; change = 1'b0; next_song = 1'b0; song_end = 1'b0;
    #12;
    chk_flags("in_reset", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #10 rst_n = 1'b1;

    // 1: idle after release
    repeat (10) step();
    chk_flags("idle", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // 2: TITLE -> BLANK x4 -> SELECT
    change = 1'b1; step(); change = 1'b0;
    for (int i = 0; i < BLANK_CYC; i++) begin
      chk_flags("t2_blank", 3'd4, 2'd0, 1'b0, 1'b0, 1'b1);
      step();
    end
    chk_flags("t2_select", 3'd1, 2'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk_flags("t2_select_hold", 3'd1, 2'd0, 1'b0, 1'b0, 1'b0);

    // 3: next_song wraps 1,2,0,1
    next_song = 1'b1; step(); next_song = 1'b0; chk("t3_idx_a", 32'(song_idx), 32'd1);
    next_song = 1'b1; step(); next_song = 1'b0; chk("t3_idx_b", 32'(song_idx), 32'd2);
    next_song = 1'b1; step(); next_song = 1'b0; chk("t3_idx_c", 32'(song_idx), 32'd0);
    step();
    next_song = 1'b1; step(); next_song = 1'b0; chk("t3_idx_d", 32'(song_idx), 32'd1);
    chk("t3_scene", 32'(scene), 32'd1);

    // change + next_song together: change wins
    change = 1'b1; next_song = 1'b1; step(); next_song = 1'b0;
    // 4: keep change high through the whole BLANK
    for (int i = 0; i < BLANK_CYC; i++) begin
      chk_flags("t4_blank", 3'd4, 2'd1, 1'b0, 1'b0, 1'b1);
      change = 1'b1;
      step();
    end
    change = 1'b0;
    chk_flags("t4_play", 3'd2, 2'd1, 1'b1, 1'b1, 1'b0);
    step();
    chk_flags("t4_play_hold", 3'd2, 2'd1, 1'b1, 1'b0, 1'b0);

    // 5: change + song_end in PLAY -> single BLANK -> RESULT
    starts = 0;
    change = 1'b1; song_end = 1'b1; step(); change = 1'b0; song_end = 1'b0;
    for (int i = 0; i < BLANK_CYC; i++) begin
      chk_flags("t5_blank", 3'd4, 2'd1, 1'b0, 1'b0, 1'b1);
      starts += int'(scene_start);
      step();
    end
    chk_flags("t5_result", 3'd3, 2'd1, 1'b0, 1'b1, 1'b0);
    starts += int'(scene_start);
    step();
    starts += int'(scene_start);
    chk("t5_one_start", 32'(starts), 32'd1);
    chk("t5_result_hold", 32'(scene), 32'd3);

    // song_end / next_song ignored in RESULT
    song_end = 1'b1; step(); song_end = 1'b0;
    chk("t5_song_end_ign", 32'(scene), 32'd3);
    next_song = 1'b1; step(); next_song = 1'b0;
    chk("t5_next_ign", 32'(song_idx), 32'd1);

    // RESULT -> SELECT, song_idx kept
    change = 1'b1; step(); change = 1'b0;
    repeat (BLANK_CYC) step();
    chk_flags("res_to_select", 3'd1, 2'd1, 1'b0, 1'b1, 1'b0);

    // SELECT -> PLAY, then song_end alone
    change = 1'b1; step(); change = 1'b0;
    repeat (BLANK_CYC) step();
    chk("to_play", 32'(scene), 32'd2);
    song_end = 1'b1; step(); song_end = 1'b0;
    chk("song_end_blank", 32'(scene), 32'd4);
    chk("song_end_pe", 32'(play_en), 32'd0);

    // 6a: async reset mid-BLANK
    step();
    #2 rst_n = 1'b0;
    #1 chk_flags("rst_mid_blank", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step();
    chk_flags("after_rst_blank", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // 6b: async reset mid-PLAY
    change = 1'b1; step(); change = 1'b0;
    repeat (BLANK_CYC) step();
    next_song = 1'b1; step(); next_song = 1'b0;
    change = 1'b1; step(); change = 1'b0;
    repeat (BLANK_CYC) step();
    step();
    chk_flags("pre_rst_play", 3'd2, 2'd1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_flags("rst_mid_play", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step();
    chk_flags("after_rst_play", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
